// File: rtl/signed_seq_divider_pkg.sv
// Shared types and helpers for the signed sequential divider.
// Helpers work on a MAX_W-bit carrier; callers sign/zero-extend in and truncate out.
package signed_div_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Magnitude of a sign-extended operand; |MIN| survives truncation back to WIDTH bits.
    function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] v);
        return v[MAX_W-1] ? -v : v;
    endfunction

    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v, input logic sign);
        return sign ? -v : v;
    endfunction

endpackage

// File: rtl/signed_seq_divider_if.sv
// Operand and result handshakes of the signed sequential divider.
// master = requester/consumer side, slave = divider.
interface signed_seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/signed_seq_divider_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
// Latency: 0 (combinational). Backpressure: none, the parent sequences it.
// Invariant rem < div_mag keeps the shifted remainder below 2^WIDTH.
module restoring_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] div_mag,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           unused_quo_msb;

    assign shifted = {rem, dvd_bit};
    assign diff    = shifted - {1'b0, div_mag};

    // Borrow out of the top bit means the trial subtract went negative: restore.
    assign rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH]};

    assign unused_quo_msb = quo[WIDTH-1];

endmodule

// File: rtl/signed_seq_divider.sv
// Signed radix-2 restoring divider: quotient truncated toward zero, remainder follows dividend.
// Latency: WIDTH cycles from accept to out_valid (1 cycle for divide-by-zero).
// Backpressure: result held in DONE until out_ready; no new accept until back in IDLE.
module signed_seq_divider
    import signed_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    signed_seq_divider_if.slave bus
);
    localparam int               CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd_sh;
    logic [WIDTH-1:0] div_mag;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] quo_acc;
    logic [WIDTH-1:0] dvd_raw;
    logic             sign_q;
    logic             sign_r;
    logic             dz_pend;
    logic             ovf_pend;

    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic             accept;
    logic             last_iter;
    logic             calc_done;

    assign accept    = bus.in_valid && (state == IDLE);
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign calc_done = (state == CALC) && (dz_pend || last_iter);

    restoring_div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_acc),
        .quo     (quo_acc),
        .dvd_bit (dvd_sh[WIDTH-1]),
        .div_mag (div_mag),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = CALC;
            end
            CALC: begin
                if (calc_done) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            dvd_sh          <= '0;
            div_mag         <= '0;
            rem_acc         <= '0;
            quo_acc         <= '0;
            dvd_raw         <= '0;
            sign_q          <= 1'b0;
            sign_r          <= 1'b0;
            dz_pend         <= 1'b0;
            ovf_pend        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
        end else if (accept) begin
            dvd_sh          <= WIDTH'(abs_mag(MAX_W'($signed(bus.dividend))));
            div_mag         <= WIDTH'(abs_mag(MAX_W'($signed(bus.divisor))));
            rem_acc         <= '0;
            quo_acc         <= '0;
            dvd_raw         <= bus.dividend;
            sign_q          <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            sign_r          <= bus.dividend[WIDTH-1];
            dz_pend         <= (bus.divisor == '0);
            ovf_pend        <= (bus.dividend == MIN_VAL) && (bus.divisor == '1);
            cnt             <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
        end else if (state == CALC) begin
            if (dz_pend) begin
                bus.quotient    <= '1;
                bus.remainder   <= dvd_raw;
                bus.div_by_zero <= 1'b1;
            end else begin
                rem_acc <= rem_nxt;
                quo_acc <= quo_nxt;
                dvd_sh  <= {dvd_sh[WIDTH-2:0], 1'b0};
                cnt     <= cnt + CW'(1);
                // Sign fix-up on the final step's outputs; MIN / -1 wraps back to MIN.
                if (last_iter) begin
                    bus.quotient  <= WIDTH'(cond_neg(MAX_W'(quo_nxt), sign_q));
                    bus.remainder <= WIDTH'(cond_neg(MAX_W'(rem_nxt), sign_r));
                    bus.overflow  <= ovf_pend;
                end
            end
        end
    end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Scoreboard bench for signed_seq_divider (WIDTH=8) with directed vectors.
module tb_signed_seq_divider;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    signed_seq_divider_if #(.WIDTH(W)) bus ();
    signed_seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string          name;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           dz;
        logic           ov;
        int             lat;
        int             acc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic prev_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timeout or unexpected event", name);
    endtask

    // Monitor: latency on first out_valid, result/flags on each handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_vld = 1'b0;
            end else begin
                if (bus.out_valid && !prev_vld) begin
                    if (sb.size() == 0) flag_fail("unexpected out_valid");
                    else check({sb[0].name, " latency"}, 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                end
                if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
                    check({sb[0].name, " quotient"}, 32'(bus.quotient), 32'(sb[0].q));
                    check({sb[0].name, " remainder"}, 32'(bus.remainder), 32'(sb[0].r));
                    check({sb[0].name, " flags"}, 32'({bus.div_by_zero, bus.overflow}),
                          32'({sb[0].dz, sb[0].ov}));
                    void'(sb.pop_front());
                end
                prev_vld = bus.out_valid;
            end
        end
    end

    task automatic send(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input logic eov, input int lat);
        exp_t e;
        int   n = 0;
        @(posedge clk); #1;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            flag_fail({name, " in_ready wait"});
        end else begin
            bus.dividend = a;
            bus.divisor  = b;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            e.name = name; e.q = eq; e.r = er; e.dz = edz; e.ov = eov;
            e.lat = lat; e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) flag_fail({name, " result wait"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic bad;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.dividend  = '0;
        bus.divisor   = '0;

        #12;
        check("reset state", 32'({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder,
                                  bus.div_by_zero, bus.overflow}), 32'({1'b1, 1'b0, 18'd0}));
        #1 rst_n = 1'b1;

        send("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 8);           wait_empty("100/7");
        send("-100/7", 8'(-100), 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0, 8);       wait_empty("-100/7");
        send("100/-7", 8'd100, 8'(-7), 8'hF2, 8'd2, 1'b0, 1'b0, 8);        wait_empty("100/-7");
        send("-100/-7", 8'(-100), 8'(-7), 8'd14, 8'hFE, 1'b0, 1'b0, 8);    wait_empty("-100/-7");
        send("127/-128", 8'd127, 8'h80, 8'd0, 8'd127, 1'b0, 1'b0, 8);      wait_empty("127/-128");
        send("-128/1", 8'h80, 8'd1, 8'h80, 8'd0, 1'b0, 1'b0, 8);           wait_empty("-128/1");
        send("-7/2", 8'(-7), 8'd2, 8'hFD, 8'hFF, 1'b0, 1'b0, 8);           wait_empty("-7/2");
        send("-128/-1", 8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, 1'b1, 8);         wait_empty("-128/-1");
        send("55/0", 8'd55, 8'd0, 8'hFF, 8'd55, 1'b1, 1'b0, 1);            wait_empty("55/0");
        send("9/3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0, 8);                wait_empty("9/3");

        // Backpressure: result must hold while new operands are offered.
        bus.out_ready = 1'b0;
        send("bp 100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 8);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.out_valid) flag_fail("bp out_valid wait");
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ~i[0];
            bus.dividend = 8'(i * 11 + 1);
            bus.divisor  = 8'(i + 2);
            @(posedge clk); #1;
            check("bp hold", 32'({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder}),
                  32'({1'b1, 1'b0, 8'd14, 8'd2}));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release", 32'({bus.in_ready, bus.out_valid}), 32'({1'b1, 1'b0}));
        wait_empty("bp");
        repeat (12) @(posedge clk);

        // Reset during the third CALC cycle.
        send("rst victim", 8'd77, 8'd5, 8'd15, 8'd2, 1'b0, 1'b0, 8);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        sb.delete();
        #1;
        check("async reset", 32'({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder,
                                  bus.div_by_zero, bus.overflow}), 32'({1'b1, 1'b0, 18'd0}));
        @(posedge clk);
        #3 rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid || !bus.in_ready) bad = 1'b1;
        end
        check("post-reset idle", 32'(bad), 32'(0));
        send("20/6", 8'd20, 8'd6, 8'd3, 8'd2, 1'b0, 1'b0, 8);              wait_empty("20/6");

        repeat (5) @(posedge clk);
        check("scoreboard drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
